// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the interconnect and its arbiters.
// Provides the default bus widths, the one-hot grant encoding and the
// arbiter state encoding, plus a helper that picks the other master.
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } grant_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    // On a tie the master that did not own the bus last wins.
    function automatic grant_e other_master(input grant_e g);
        return (g == GNT_M0) ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Outstanding-request counter and hung-slave watchdog for one grant.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_active        arbiter is in GRANT; both counters clear when low
//   i_issue         a request was accepted by the slave this cycle
//   i_resp          the slave returned ACK or ERR this cycle
//   o_full          outstanding counter is at its maximum
//   o_expired       the next cycle is the TIMEOUT-th cycle without progress
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255,  // must be >= 2
    parameter int OUTW    = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_active,
    input  logic i_issue,
    input  logic i_resp,
    output logic o_full,
    output logic o_expired
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [OUTW-1:0] CNT_MAX = '1;
    // The abort cycle itself is the TIMEOUT-th silent cycle, so the arbiter
    // must decide one cycle earlier, when TIMEOUT-1 silent cycles have run.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

    logic [OUTW-1:0] r_count;
    logic [WDW-1:0]  r_wd;
    logic            w_inc;
    logic            w_dec;
    logic            w_counting;

    assign w_inc      = i_issue && !o_full;
    assign w_dec      = i_resp && (r_count != '0);
    assign w_counting = i_active && (r_count != '0) && !i_resp;

    assign o_full    = (r_count == CNT_MAX);
    assign o_expired = w_counting && (r_wd == WD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active) begin
            r_count <= '0;
            r_wd    <= '0;
        end else begin
            if (w_inc && !w_dec)
                r_count <= r_count + OUTW'(1);
            else if (w_dec && !w_inc)
                r_count <= r_count - OUTW'(1);

            if (w_counting)
                r_wd <= r_wd + WDW'(1);
            else
                r_wd <= '0;
        end
    end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master round-robin arbiter in front of one Wishbone pipelined slave path.
// The grant is registered and held for the owner's whole CYC; a watchdog turns
// a hung slave into a one-cycle ERR to the owner.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_mX_* / o_mX_*         master X request inputs and response outputs
//   o_wb_* / i_wb_*         shared slave path
//   o_grant                 one-hot owner (01 = m0, 10 = m1, 00 = none)
//   o_timeout               one-cycle pulse when the watchdog aborts a grant
module wb_arbiter_2to1
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255,
    parameter int OUTW    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_m0_cyc,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data,
    input  logic [DW/8-1:0] i_m0_sel,
    output logic            o_m0_ack,
    output logic            o_m0_stall,
    output logic            o_m0_err,
    output logic [DW-1:0]   o_m0_data,
    input  logic            i_m1_cyc,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data,
    input  logic [DW/8-1:0] i_m1_sel,
    output logic            o_m1_ack,
    output logic            o_m1_stall,
    output logic            o_m1_err,
    output logic [DW-1:0]   o_m1_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data,
    output logic [1:0]      o_grant,
    output logic            o_timeout
);

    state_e r_state, w_state_next;
    grant_e r_grant, w_grant_next;
    grant_e r_last_owner, w_last_next;
    logic   r_abort_pulse;

    logic            w_own_m1;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_own_we;
    logic [AW-1:0]   w_own_addr;
    logic [DW-1:0]   w_own_data;
    logic [DW/8-1:0] w_own_sel;
    logic            w_full;
    logic            w_expired;

    // Owner request path, selected by the registered grant.
    assign w_own_m1   = (r_grant == GNT_M1);
    assign w_own_cyc  = ((r_grant == GNT_M0) && i_m0_cyc) || ((r_grant == GNT_M1) && i_m1_cyc);
    assign w_own_stb  = w_own_m1 ? i_m1_stb  : i_m0_stb;
    assign w_own_we   = w_own_m1 ? i_m1_we   : i_m0_we;
    assign w_own_addr = w_own_m1 ? i_m1_addr : i_m0_addr;
    assign w_own_data = w_own_m1 ? i_m1_data : i_m0_data;
    assign w_own_sel  = w_own_m1 ? i_m1_sel  : i_m0_sel;

    assign o_grant = r_grant;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .OUTW    (OUTW)
    ) u_wd (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_active  (r_state == ST_GRANT),
        .i_issue   (o_wb_stb && !i_wb_stall),
        .i_resp    (i_wb_ack || i_wb_err),
        .o_full    (w_full),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= GNT_NONE;
            r_last_owner  <= GNT_M1;
            r_abort_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_last_owner  <= w_last_next;
            r_abort_pulse <= (r_state == ST_GRANT) && (w_state_next == ST_ABORT);
        end
    end

    // Next-state logic. Every release passes through IDLE, which guarantees
    // at least one idle cycle between two grants.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = other_master(r_last_owner);
                end else if (i_m0_cyc) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = GNT_M0;
                end else if (i_m1_cyc) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = GNT_M1;
                end
            end
            ST_GRANT, ST_ABORT: begin
                // A CYC drop wins over a simultaneous expiry: the owner has
                // already given up, so no error is reported.
                if (!w_own_cyc) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = GNT_NONE;
                    w_last_next  = r_grant;
                end else if ((r_state == ST_GRANT) && w_expired) begin
                    w_state_next = ST_ABORT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = GNT_NONE;
            end
        endcase
    end

    // Output logic.
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m0_data  = '0;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_data  = '0;
        o_timeout  = 1'b0;
        case (r_state)
            ST_GRANT: begin
                o_wb_cyc  = w_own_cyc;
                // STB is withheld while the counter is full so the slave cannot
                // accept a request the owner sees as stalled; STB without CYC is
                // never forwarded.
                o_wb_stb  = w_own_cyc && w_own_stb && !w_full;
                o_wb_we   = w_own_we;
                o_wb_addr = w_own_addr;
                o_wb_data = w_own_data;
                o_wb_sel  = w_own_sel;
                if (w_own_m1) begin
                    o_m1_stall = i_wb_stall || w_full;
                    o_m1_ack   = i_wb_ack;
                    o_m1_err   = i_wb_err;
                    o_m1_data  = i_wb_data;
                end else begin
                    o_m0_stall = i_wb_stall || w_full;
                    o_m0_ack   = i_wb_ack;
                    o_m0_err   = i_wb_err;
                    o_m0_data  = i_wb_data;
                end
            end
            ST_ABORT: begin
                // Slave responses are ignored here; only the abort error is sent.
                o_timeout = r_abort_pulse;
                if (w_own_m1)
                    o_m1_err = r_abort_pulse;
                else
                    o_m0_err = r_abort_pulse;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 (TIMEOUT = 8, OUTW = 2).
// Responses seen on the master ports are checked by a scoreboard monitor
// against a queue filled by the stimulus; bus/grant levels are checked inline.
module tb_wb_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;

    // Response flag patterns: {m1_ack, m1_err, m0_ack, m0_err}
    localparam logic [3:0] R_M0_ACK = 4'b0010;
    localparam logic [3:0] R_M0_ERR = 4'b0001;
    localparam logic [3:0] R_M1_ACK = 4'b1000;

    typedef struct packed {
        logic [3:0]    flags;
        logic [DW-1:0] data;
    } exp_t;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [DW-1:0]   m0_wdata, m1_wdata;
    logic [DW/8-1:0] m0_sel, m1_sel;
    logic            o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
    logic [DW-1:0]   o_m0_data, o_m1_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            wb_ack, wb_stall, wb_err;
    logic [DW-1:0]   wb_rdata;
    logic [1:0]      o_grant;
    logic            o_timeout;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    wb_arbiter_2to1 #(.AW(AW), .DW(DW), .TIMEOUT(8), .OUTW(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdata), .i_m0_sel(m0_sel),
        .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdata), .i_m1_sel(m1_sel),
        .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_resp(input logic [3:0] flags, input logic [DW-1:0] data);
        exp_q.push_back({flags, data});
    endtask

    // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    // Scoreboard monitor: every ACK/ERR on a master port must match the next
    // expected response in order, including which master receives it.
    always @(negedge i_clk) begin
        logic [3:0]    got_flags;
        logic [DW-1:0] got_data;
        exp_t          e;
        got_flags = {o_m1_ack, o_m1_err, o_m0_ack, o_m0_err};
        got_data  = (o_m1_ack || o_m1_err) ? o_m1_data : o_m0_data;
        if (got_flags != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL resp_unexpected: got flags %b data 0x%08h, want none at %0t",
                         got_flags, got_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_flags", 32'(got_flags), 32'(e.flags));
                check("resp_data", got_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_reset = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
        wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;

        // ---------------- reset values
        tick(); tick(); mid();
        check("rst_grant", o_grant, 2'b00);
        check("rst_wb_cyc", o_wb_cyc, 0);
        check("rst_wb_stb", o_wb_stb, 0);
        check("rst_m0_stall", o_m0_stall, 1);
        check("rst_m1_stall", o_m1_stall, 1);
        check("rst_timeout", o_timeout, 0);

        // ---------------- tie after reset, then alternation
        tick(); i_reset = 0; m0_cyc = 1; m1_cyc = 1; mid();
        check("tie_idle_grant", o_grant, 2'b00);
        check("tie_idle_wb_cyc", o_wb_cyc, 0);
        tick(); mid();
        check("tie1_grant_m0", o_grant, 2'b01);
        check("tie1_m1_stall", o_m1_stall, 1);
        tick(); m0_cyc = 0; mid();
        check("tie1_hold", o_grant, 2'b01);
        tick(); m0_cyc = 1; mid();
        check("tie_gap1", o_grant, 2'b00);
        tick(); mid();
        check("tie2_grant_m1", o_grant, 2'b10);
        tick(); m1_cyc = 0; mid();
        tick(); m1_cyc = 1; mid();
        check("tie_gap2", o_grant, 2'b00);
        tick(); mid();
        check("tie3_grant_m0", o_grant, 2'b01);
        tick(); m0_cyc = 0; m1_cyc = 0; mid();
        tick(); mid();
        check("tie_release", o_grant, 2'b00);

        // ---------------- single master write
        tick(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h8000_0000;
        m0_wdata = 32'h0000_002A; m0_sel = 4'hF; mid();
        check("wr_grant_lat", o_grant, 2'b00);
        check("wr_m0_stall_idle", o_m0_stall, 1);
        tick(); mid();
        check("wr_grant", o_grant, 2'b01);
        check("wr_wb_cyc", o_wb_cyc, 1);
        check("wr_wb_stb", o_wb_stb, 1);
        check("wr_wb_we", o_wb_we, 1);
        check("wr_wb_addr", o_wb_addr, 32'h8000_0000);
        check("wr_wb_data", o_wb_data, 32'h0000_002A);
        check("wr_wb_sel", o_wb_sel, 4'hF);
        check("wr_m0_stall", o_m0_stall, 0);
        tick(); m0_stb = 0; wb_ack = 1; wb_rdata = '0; expect_resp(R_M0_ACK, '0); mid();
        check("wr_wb_stb_off", o_wb_stb, 0);
        tick(); wb_ack = 0; m0_cyc = 0; m0_we = 0; mid();
        check("wr_hold", o_grant, 2'b01);
        tick(); mid();
        check("wr_release", o_grant, 2'b00);

        // ---------------- m1 pipelined read burst, m0 held off
        tick(); m1_cyc = 1; m1_stb = 1; m1_addr = 32'h0; m0_cyc = 1; m0_stb = 1;
        m0_addr = 32'hDEAD_0000; mid();
        check("bu_grant_lat", o_grant, 2'b00);
        tick(); mid();
        check("bu_grant_m1", o_grant, 2'b10);
        check("bu_addr0", o_wb_addr, 32'h0);
        check("bu_m1_stall0", o_m1_stall, 0);
        check("bu_m0_stall0", o_m0_stall, 1);
        tick(); m1_addr = 32'h4; wb_stall = 1; wb_ack = 1; wb_rdata = 32'h11;
        expect_resp(R_M1_ACK, 32'h11); mid();
        check("bu_m1_stall_mirror", o_m1_stall, 1);
        check("bu_addr1", o_wb_addr, 32'h4);
        check("bu_m0_data_zero", o_m0_data, 32'h0);
        check("bu_m0_stall1", o_m0_stall, 1);
        tick(); wb_stall = 0; wb_ack = 0; mid();
        check("bu_m1_stall_clear", o_m1_stall, 0);
        check("bu_m0_stall2", o_m0_stall, 1);
        tick(); m1_addr = 32'h8; wb_ack = 1; wb_rdata = 32'h22; expect_resp(R_M1_ACK, 32'h22); mid();
        check("bu_addr2", o_wb_addr, 32'h8);
        check("bu_m0_stall3", o_m0_stall, 1);
        tick(); m1_addr = 32'hC; wb_rdata = 32'h33; expect_resp(R_M1_ACK, 32'h33); mid();
        check("bu_addr3", o_wb_addr, 32'hC);
        check("bu_m0_stall4", o_m0_stall, 1);
        tick(); m1_stb = 0; wb_rdata = 32'h44; expect_resp(R_M1_ACK, 32'h44); mid();
        check("bu_m0_stall5", o_m0_stall, 1);
        tick(); wb_ack = 0; wb_rdata = '0; m1_cyc = 0; m0_cyc = 0; m0_stb = 0; mid();
        check("bu_hold", o_grant, 2'b10);
        tick(); mid();
        check("bu_release", o_grant, 2'b00);

        // ---------------- counter full (OUTW = 2 -> 3 outstanding)
        tick(); m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100; mid();
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            check("full_issue_open", o_m0_stall, 0);
        end
        tick(); mid();
        check("full_stall", o_m0_stall, 1);
        check("full_wb_stb", o_wb_stb, 0);
        tick(); wb_ack = 1; wb_rdata = 32'hA1; expect_resp(R_M0_ACK, 32'hA1); mid();
        check("full_stall_on_ack", o_m0_stall, 1);
        tick(); wb_ack = 0; mid();
        check("full_one_more", o_m0_stall, 0);
        tick(); m0_stb = 0; mid();
        check("full_again", o_m0_stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); wb_ack = 1; wb_rdata = 32'hA2 + 32'(i); expect_resp(R_M0_ACK, 32'hA2 + 32'(i));
        end
        tick(); wb_ack = 0; wb_rdata = '0; m0_cyc = 0; mid();
        tick(); mid();
        check("full_release", o_grant, 2'b00);

        // ---------------- watchdog timeout (TIMEOUT = 8)
        tick(); m0_cyc = 1; m0_stb = 1; m0_addr = 32'h200; mid();
        tick(); mid();
        check("to_grant", o_grant, 2'b01);
        check("to_accept", o_m0_stall, 0);
        tick(); m0_stb = 0; mid();
        for (int k = 2; k <= 7; k++) begin
            tick(); mid();
            check("to_quiet_timeout", o_timeout, 0);
            check("to_quiet_cyc", o_wb_cyc, 1);
        end
        tick(); expect_resp(R_M0_ERR, '0); mid();
        check("to_pulse", o_timeout, 1);
        check("to_wb_cyc", o_wb_cyc, 0);
        tick(); mid();
        check("to_pulse_end", o_timeout, 0);
        check("to_hold_grant", o_grant, 2'b01);
        check("to_hold_cyc", o_wb_cyc, 0);
        tick(); m0_cyc = 0; mid();
        tick(); mid();
        check("to_release", o_grant, 2'b00);

        // ---------------- reset with m1 holding two outstanding requests
        tick(); m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300; mid();
        tick(); mid();
        check("rs_grant_m1", o_grant, 2'b10);
        tick(); m1_addr = 32'h304; mid();
        check("rs_second_issue", o_m1_stall, 0);
        tick(); m1_stb = 0; i_reset = 1; mid();
        tick(); i_reset = 0; m0_cyc = 1; mid();
        check("rs_grant", o_grant, 2'b00);
        check("rs_wb_cyc", o_wb_cyc, 0);
        check("rs_m1_stall", o_m1_stall, 1);
        tick(); m0_stb = 1; m0_addr = 32'h400; mid();
        check("rs_tie_m0", o_grant, 2'b01);
        check("rs_addr", o_wb_addr, 32'h400);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick(); mid();
            end
            check("rs_count_cleared", o_m0_stall, 0);
            check("rs_m1_held", o_m1_stall, 1);
        end
        tick(); m0_stb = 0; wb_ack = 1; wb_rdata = 32'hB1; expect_resp(R_M0_ACK, 32'hB1); mid();
        check("rs_full", o_m0_stall, 1);
        tick(); wb_rdata = 32'hB2; expect_resp(R_M0_ACK, 32'hB2);
        tick(); wb_rdata = 32'hB3; expect_resp(R_M0_ACK, 32'hB3);
        tick(); wb_ack = 0; wb_rdata = '0; m0_cyc = 0; m1_cyc = 0; mid();
        check("rs_hold", o_grant, 2'b01);
        tick(); mid();
        check("rs_release", o_grant, 2'b00);

        tick(); tick(); mid();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
